// File: rtl/execution_sequencer.sv
// execution_sequencer
// Issues decoded instructions onto the execution datapath, one at a time
// through a valid/ready handshake.
//  - Single-cycle ops (add/sub/slt) write back on the cycle after acceptance.
//  - Multiplies start the multiplier, then write back after MUL_LATENCY cycles.
//  - Divides start the divider, then write back after divDone, or raise an
//    error if divDone does not arrive within DIV_TIMEOUT cycles.
//  - Writes to x0 are suppressed. Decode errors, illegal selects and divider
//    timeouts set a sticky errorFlag.
// Ports:
//  clk, reset              clock, synchronous active-high reset
//  instrValid/instrReady   decoder handshake
//  resultSelectIn          0 add/sub, 1 mul, 2 div, 3 rem, 5 slt (4,6,7 illegal)
//  writeSelectIn           destination register
//  writeEnableIn           instruction writes rd
//  decodeError             decoder error flag
//  divDone                 divider result valid pulse
//  mulStart/divStart       one-cycle start pulses
//  regWriteEnable/Addr     register file write port
//  resultSelectOut         result mux select, held between acceptances
//  busy                    multi-cycle operation in flight
//  errorFlag               sticky error
module execution_sequencer #(
  parameter int REGADDR_W   = 5,
  parameter int RSEL_W      = 3,
  parameter int MUL_LATENCY = 3,
  parameter int DIV_TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 instrValid,
  output logic                 instrReady,
  input  logic [RSEL_W-1:0]    resultSelectIn,
  input  logic [REGADDR_W-1:0] writeSelectIn,
  input  logic                 writeEnableIn,
  input  logic                 decodeError,
  input  logic                 divDone,
  output logic                 mulStart,
  output logic                 divStart,
  output logic                 regWriteEnable,
  output logic [REGADDR_W-1:0] regWriteAddr,
  output logic [RSEL_W-1:0]    resultSelectOut,
  output logic                 busy,
  output logic                 errorFlag
);

  localparam int CNT_MAX = (MUL_LATENCY > DIV_TIMEOUT) ? MUL_LATENCY : DIV_TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [RSEL_W-1:0] SEL_ADD = RSEL_W'(0);
  localparam logic [RSEL_W-1:0] SEL_MUL = RSEL_W'(1);
  localparam logic [RSEL_W-1:0] SEL_DIV = RSEL_W'(2);
  localparam logic [RSEL_W-1:0] SEL_REM = RSEL_W'(3);
  localparam logic [RSEL_W-1:0] SEL_SLT = RSEL_W'(5);

  typedef enum logic [1:0] {S_IDLE, S_MUL_WAIT, S_DIV_WAIT} state_e;

  state_e                state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  wb_en_q;     // latched rd write enable, x0 already masked
  logic [REGADDR_W-1:0]  addr_q;
  logic [RSEL_W-1:0]     rsel_q;
  logic                  mul_start_q, div_start_q, reg_we_q, err_q;
  logic                  wb_en_d;
  logic                  sel_legal;

  assign wb_en_d   = writeEnableIn && (writeSelectIn != '0);
  assign sel_legal = (resultSelectIn == SEL_ADD) || (resultSelectIn == SEL_MUL) ||
                     (resultSelectIn == SEL_DIV) || (resultSelectIn == SEL_REM) ||
                     (resultSelectIn == SEL_SLT);

  // Reset gates ready directly so the decoder sees 0 for the whole reset window.
  assign instrReady      = !reset && (state_q == S_IDLE);
  assign busy            = (state_q != S_IDLE);
  assign mulStart        = mul_start_q;
  assign divStart        = div_start_q;
  assign regWriteEnable  = reg_we_q;
  assign regWriteAddr    = addr_q;
  assign resultSelectOut = rsel_q;
  assign errorFlag       = err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      wb_en_q     <= 1'b0;
      addr_q      <= '0;
      rsel_q      <= '0;
      mul_start_q <= 1'b0;
      div_start_q <= 1'b0;
      reg_we_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      mul_start_q <= 1'b0;
      div_start_q <= 1'b0;
      reg_we_q    <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (instrValid) begin
            rsel_q  <= resultSelectIn;
            addr_q  <= writeSelectIn;
            wb_en_q <= wb_en_d;
            if (decodeError || !sel_legal) begin
              err_q <= 1'b1;
            end else begin
              case (resultSelectIn)
                SEL_MUL: begin
                  // Counter runs MUL_LATENCY wait cycles, exiting when it hits 0.
                  mul_start_q <= 1'b1;
                  cnt_q       <= CNT_W'(MUL_LATENCY - 1);
                  state_q     <= S_MUL_WAIT;
                end
                SEL_DIV, SEL_REM: begin
                  div_start_q <= 1'b1;
                  cnt_q       <= CNT_W'(DIV_TIMEOUT - 1);
                  state_q     <= S_DIV_WAIT;
                end
                default: reg_we_q <= wb_en_d;   // add/sub/slt
              endcase
            end
          end
        end
        S_MUL_WAIT: begin
          if (cnt_q == '0) begin
            reg_we_q <= wb_en_q;
            state_q  <= S_IDLE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_DIV_WAIT: begin
          // divDone coinciding with our own divStart pulse is stale; ignore it.
          if (divDone && !div_start_q) begin
            reg_we_q <= wb_en_q;
            state_q  <= S_IDLE;
          end else if (cnt_q == '0) begin
            err_q   <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_execution_sequencer.sv
module tb_execution_sequencer;
  localparam int L  = 3;
  localparam int T  = 64;
  localparam int NR = 1500;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       instrValid = 1'b0;
  logic       instrReady;
  logic [2:0] resultSelectIn = '0;
  logic [4:0] writeSelectIn = '0;
  logic       writeEnableIn = 1'b0;
  logic       decodeError = 1'b0;
  logic       divDone = 1'b0;
  logic       mulStart, divStart, regWriteEnable, busy, errorFlag;
  logic [4:0] regWriteAddr;
  logic [2:0] resultSelectOut;

  int total = 0;
  int bad = 0;

  execution_sequencer #(.REGADDR_W(5), .RSEL_W(3), .MUL_LATENCY(L), .DIV_TIMEOUT(T)) dut (
    .clk(clk), .reset(reset), .instrValid(instrValid), .instrReady(instrReady),
    .resultSelectIn(resultSelectIn), .writeSelectIn(writeSelectIn),
    .writeEnableIn(writeEnableIn), .decodeError(decodeError), .divDone(divDone),
    .mulStart(mulStart), .divStart(divStart), .regWriteEnable(regWriteEnable),
    .regWriteAddr(regWriteAddr), .resultSelectOut(resultSelectOut), .busy(busy),
    .errorFlag(errorFlag)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input int v, input int sel, input int rd, input int we, input int de);
    instrValid     = v[0];
    resultSelectIn = 3'(sel);
    writeSelectIn  = 5'(rd);
    writeEnableIn  = we[0];
    decodeError    = de[0];
  endtask

  // Reset, check reset values, release, check ready comes up.
  task automatic do_reset();
    drive(0, 0, 0, 0, 0);
    divDone = 1'b0;
    reset = 1'b1;
    tick(); tick();
    chk("rst_ready", int'(instrReady), 0);
    chk("rst_wen",   int'(regWriteEnable), 0);
    chk("rst_addr",  int'(regWriteAddr), 0);
    chk("rst_ms",    int'(mulStart), 0);
    chk("rst_ds",    int'(divStart), 0);
    chk("rst_busy",  int'(busy), 0);
    chk("rst_err",   int'(errorFlag), 0);
    chk("rst_rsel",  int'(resultSelectOut), 0);
    reset = 1'b0;
    tick();
    chk("rst_ready_after", int'(instrReady), 1);
  endtask

  typedef struct {
    int v, sel, rd, we, de;                          // inputs for this cycle
    int e_rdy, e_wen, e_addr, e_ms, e_busy, e_err, e_rsel;  // outputs next cycle
  } vec_t;

  // Random-phase reference model: expectations indexed by absolute cycle.
  bit e_wb [NR+16];
  int e_ad [NR+16];
  bit e_ms [NR+16];
  bit e_ds [NR+16];

  initial begin
    vec_t tbl[13];
    tbl[0]  = '{1, 0,  5, 1, 0,  1, 1,  5, 0, 0, 0, 0};  // add rd5
    tbl[1]  = '{1, 5,  6, 1, 0,  1, 1,  6, 0, 0, 0, 5};  // slt rd6 back-to-back
    tbl[2]  = '{1, 0,  0, 1, 0,  1, 0,  0, 0, 0, 0, 0};  // add to x0
    tbl[3]  = '{1, 1,  7, 1, 0,  0, 0,  0, 1, 1, 0, 1};  // mul rd7
    tbl[4]  = '{1, 0,  8, 1, 0,  0, 0,  0, 0, 1, 0, 1};  // stalled add
    tbl[5]  = '{1, 0,  8, 1, 0,  0, 0,  0, 0, 1, 0, 1};
    tbl[6]  = '{1, 0,  8, 1, 0,  1, 1,  7, 0, 0, 0, 1};  // mul writeback
    tbl[7]  = '{1, 0,  8, 1, 0,  1, 1,  8, 0, 0, 0, 0};  // held add accepted
    tbl[8]  = '{1, 0,  3, 0, 0,  1, 0,  0, 0, 0, 0, 0};  // writeEnableIn=0
    tbl[9]  = '{1, 0,  4, 1, 1,  1, 0,  0, 0, 0, 1, 0};  // decodeError
    tbl[10] = '{1, 4,  4, 1, 0,  1, 0,  0, 0, 0, 1, 4};  // illegal select
    tbl[11] = '{1, 0, 10, 1, 0,  1, 1, 10, 0, 0, 1, 0};  // error stays sticky
    tbl[12] = '{0, 0,  0, 0, 0,  1, 0,  0, 0, 0, 1, 0};

    do_reset();
    foreach (tbl[i]) begin
      drive(tbl[i].v, tbl[i].sel, tbl[i].rd, tbl[i].we, tbl[i].de);
      tick();
      chk($sformatf("tbl%0d_ready", i), int'(instrReady), tbl[i].e_rdy);
      chk($sformatf("tbl%0d_wen", i),   int'(regWriteEnable), tbl[i].e_wen);
      if (tbl[i].e_wen != 0) chk($sformatf("tbl%0d_addr", i), int'(regWriteAddr), tbl[i].e_addr);
      chk($sformatf("tbl%0d_ms", i),    int'(mulStart), tbl[i].e_ms);
      chk($sformatf("tbl%0d_ds", i),    int'(divStart), 0);
      chk($sformatf("tbl%0d_busy", i),  int'(busy), tbl[i].e_busy);
      chk($sformatf("tbl%0d_err", i),   int'(errorFlag), tbl[i].e_err);
      chk($sformatf("tbl%0d_rsel", i),  int'(resultSelectOut), tbl[i].e_rsel);
    end

    // Divide with completion; divDone in the divStart cycle must be ignored.
    do_reset();
    drive(1, 2, 9, 1, 0);
    tick();
    drive(0, 0, 0, 0, 0);
    chk("div_ds", int'(divStart), 1);
    chk("div_busy", int'(busy), 1);
    chk("div_ready0", int'(instrReady), 0);
    chk("div_rsel", int'(resultSelectOut), 2);
    divDone = 1'b1;
    tick();
    divDone = 1'b0;
    chk("div_early_done_ignored", int'(instrReady), 0);
    chk("div_early_no_wb", int'(regWriteEnable), 0);
    chk("div_ds_once", int'(divStart), 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("div_wait_ready", int'(instrReady), 0);
    end
    divDone = 1'b1;
    tick();
    divDone = 1'b0;
    chk("div_wen", int'(regWriteEnable), 1);
    chk("div_addr", int'(regWriteAddr), 9);
    chk("div_ready1", int'(instrReady), 1);
    chk("div_busy0", int'(busy), 0);
    chk("div_err0", int'(errorFlag), 0);

    // Divide timeout: rem rd11 with divDone never returned.
    drive(1, 3, 11, 1, 0);
    tick();
    drive(0, 0, 0, 0, 0);
    chk("to_ds", int'(divStart), 1);
    for (int i = 2; i <= T; i++) begin
      tick();
      chk("to_wait_ready", int'(instrReady), 0);
      chk("to_wait_err", int'(errorFlag), 0);
    end
    tick();
    chk("to_err", int'(errorFlag), 1);
    chk("to_ready", int'(instrReady), 1);
    chk("to_no_wb", int'(regWriteEnable), 0);
    chk("to_busy", int'(busy), 0);
    tick();
    chk("to_no_wb_late", int'(regWriteEnable), 0);

    // Reset in the second MUL_WAIT cycle abandons the multiply.
    do_reset();
    drive(1, 1, 12, 1, 0);
    tick();
    drive(0, 0, 0, 0, 0);
    chk("mr_ms", int'(mulStart), 1);
    tick();
    reset = 1'b1;
    tick();
    chk("mr_ready", int'(instrReady), 0);
    chk("mr_busy", int'(busy), 0);
    chk("mr_rsel", int'(resultSelectOut), 0);
    chk("mr_addr", int'(regWriteAddr), 0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("mr_no_wb", int'(regWriteEnable), 0);
      chk("mr_ready_up", int'(instrReady), 1);
    end

    // Reset during a divide; a late divDone must not write back.
    drive(1, 2, 13, 1, 0);
    tick();
    drive(0, 0, 0, 0, 0);
    chk("dr_ds", int'(divStart), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    divDone = 1'b1;
    tick();
    divDone = 1'b0;
    chk("dr_no_wb", int'(regWriteEnable), 0);
    chk("dr_ready", int'(instrReady), 1);
    tick();
    chk("dr_no_wb2", int'(regWriteEnable), 0);
    chk("dr_err", int'(errorFlag), 0);

    // Randomized traffic against a cycle-indexed behavioural model.
    do_reset();
    begin
      int rf = 0, dacc = 0, err_m = 0, rsel_m = 0, d_wen = 0, d_rd = 0;
      bit in_div = 0, never = 0;
      for (int c = 0; c < NR + 16; c++) begin
        e_wb[c] = 0; e_ad[c] = 0; e_ms[c] = 0; e_ds[c] = 0;
      end
      for (int c = 0; c < NR; c++) begin
        int rdy, v, r, sel, rd, we, de, dd;
        rdy = (c >= rf) ? 1 : 0;
        chk("r_ready", int'(instrReady), rdy);
        chk("r_busy", int'(busy), 1 - rdy);
        chk("r_ms", int'(mulStart), int'(e_ms[c]));
        chk("r_ds", int'(divStart), int'(e_ds[c]));
        chk("r_wen", int'(regWriteEnable), int'(e_wb[c]));
        if (e_wb[c]) chk("r_addr", int'(regWriteAddr), e_ad[c]);
        chk("r_err", int'(errorFlag), err_m);
        chk("r_rsel", int'(resultSelectOut), rsel_m);

        v  = ($urandom % 3 != 0) ? 1 : 0;
        r  = int'($urandom_range(0, 15));
        sel = (r < 6) ? 0 : (r < 8) ? 5 : (r < 10) ? 1 : (r < 12) ? 2 : (r < 14) ? 3 :
              (r == 14) ? 4 + 2 * int'($urandom_range(0, 1)) : 7;
        rd = int'($urandom_range(0, 31));
        we = ($urandom % 4 != 0) ? 1 : 0;
        de = ($urandom % 40 == 0) ? 1 : 0;
        dd = in_div ? ((!never && $urandom % 8 == 0) ? 1 : 0) : (($urandom % 4 == 0) ? 1 : 0);
        drive(v, sel, rd, we, de);
        divDone = dd[0];

        if (rdy == 1 && v == 1) begin
          rsel_m = sel;
          if (de == 1 || sel == 4 || sel == 6 || sel == 7) begin
            err_m = 1;
          end else if (sel == 0 || sel == 5) begin
            e_wb[c+1] = (we == 1 && rd != 0);
            e_ad[c+1] = rd;
          end else if (sel == 1) begin
            e_ms[c+1]   = 1;
            rf          = c + 1 + L;
            e_wb[c+1+L] = (we == 1 && rd != 0);
            e_ad[c+1+L] = rd;
          end else begin
            e_ds[c+1] = 1;
            in_div = 1;
            dacc   = c;
            rf     = 1 << 30;
            never  = ($urandom % 4 == 0);
            d_wen  = (we == 1 && rd != 0) ? 1 : 0;
            d_rd   = rd;
          end
        end else if (in_div) begin
          if (dd == 1 && c >= dacc + 2) begin
            e_wb[c+1] = d_wen[0];
            e_ad[c+1] = d_rd;
            rf = c + 1;
            in_div = 0;
          end else if (c == dacc + T) begin
            err_m = 1;
            rf = c + 1;
            in_div = 0;
          end
        end
        tick();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
